// File: rtl/stopwatch.sv
// MM:SS BCD stopwatch controlled by synchronised start/pause/clear command levels.
// Define STOPWATCH_SATURATE_EN to hold at 59:59 instead of wrapping to 00:00.
module stopwatch #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [3:0]  digit,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        rollover
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                        state_reg, state_next;
    logic [SYNC_STAGES-1:0][2:0]   sync_reg;
    logic [PW-1:0]                 presc_reg, presc_next;
    logic [3:0][3:0]               dig_reg, dig_next;
    logic [3:0]                    at_max;
    logic [4:0]                    carry;
    logic                          rollover_reg;
    logic                          s_start, s_pause, s_clear;
    logic                          hold;
    logic                          tick;

    // Command bits travel together as {clear, pause, start}; index 0 is the first stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], {clear, pause, start}};
        end
    end

    assign s_start = sync_reg[SYNC_STAGES-1][0];
    assign s_pause = sync_reg[SYNC_STAGES-1][1];
    assign s_clear = sync_reg[SYNC_STAGES-1][2];

`ifdef STOPWATCH_SATURATE_EN
    assign hold = (dig_reg == 16'h5959);
`else
    assign hold = 1'b0;
`endif

    assign tick = (state_reg == RUN) && !hold && (presc_reg == PW'(TICK_DIV - 1));

    always_comb begin
        state_next = state_reg;
        if (s_clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (s_start && !s_pause) state_next = RUN;
                RUN:     if (s_pause)             state_next = PAUSED;
                PAUSED:  if (s_start && !s_pause) state_next = RUN;
                default:                          state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        presc_next = presc_reg;
        if (s_clear || state_reg == IDLE) begin
            presc_next = '0;
        end else if (state_reg == RUN && !hold) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
        end
    end

    // BCD ripple: even digits are units (0-9), odd digits are tens (0-5).
    assign carry[0] = tick;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi % 2 == 0) ? 4'd9 : 4'd5;
            assign at_max[gi]    = (dig_reg[gi] == LIM);
            assign dig_next[gi]  = carry[gi] ? (at_max[gi] ? 4'd0 : dig_reg[gi] + 4'd1)
                                             : dig_reg[gi];
            assign carry[gi + 1] = carry[gi] & at_max[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            dig_reg      <= '0;
            rollover_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            dig_reg      <= s_clear ? '0 : dig_next;
            rollover_reg <= !s_clear && carry[4];
        end
    end

    assign time_bcd = dig_reg;
    assign digit    = dig_reg[0];
    assign running  = (state_reg == RUN);
    assign rollover = rollover_reg;

endmodule

// File: tb/tb_stopwatch.sv
// Randomised self-checking bench for stopwatch: an integer-seconds reference model
// is stepped every clock and compared against all outputs.
module tb_stopwatch;

    localparam int TICK_DIV    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_SECS    = 59 * 60 + 59;

`ifdef STOPWATCH_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  digit;
    logic [15:0] time_bcd;
    logic        running;
    logic        rollover;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: elapsed whole seconds plus the partial-second cycle count.
    int         m_mode = 0;          // 0 idle, 1 run, 2 paused
    int         m_secs = 0;
    int         m_frac = 0;
    bit         m_roll = 1'b0;
    int         m_roll_cnt = 0;
    int         dut_roll_cnt = 0;
    logic [2:0] m_hist[$];

    stopwatch #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .digit    (digit),
        .time_bcd (time_bcd),
        .running  (running),
        .rollover (rollover)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset_hist();
        m_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(3'b000);
    endtask

    // One rising edge of the reference, using the inputs present at that edge.
    task automatic model_edge();
        logic [2:0] c;
        if (!reset_n) begin
            model_reset_hist();
            m_mode = 0;
            m_secs = 0;
            m_frac = 0;
            m_roll = 1'b0;
            return;
        end
        c = m_hist.pop_front();
        m_hist.push_back({clear, pause, start});
        m_roll = 1'b0;
        if (c[2]) begin
            m_mode = 0;
            m_secs = 0;
            m_frac = 0;
            return;
        end
        if (m_mode == 1 && !(SAT && m_secs == MAX_SECS)) begin
            if (m_frac == TICK_DIV - 1) begin
                m_frac = 0;
                if (m_secs == MAX_SECS) begin
                    m_secs = 0;
                    m_roll = 1'b1;
                    m_roll_cnt++;
                end else begin
                    m_secs++;
                end
            end else begin
                m_frac++;
            end
        end
        if ((m_mode == 0 || m_mode == 2) && c[0] && !c[1]) m_mode = 1;
        else if (m_mode == 1 && c[1])                    m_mode = 2;
    endtask

    task automatic run_seg(input bit r, input bit s, input bit p, input bit c, input int len);
        int bad0;
        bad0 = n_bad;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            reset_n = r;
            start   = s;
            pause   = p;
            clear   = c;
            @(posedge clk);
            model_edge();
            #1;
            if (rollover === 1'b1) dut_roll_cnt++;
            check("time_bcd", 32'(time_bcd), 32'(to_bcd(m_secs)));
            check("digit",    32'(digit),    32'(to_bcd(m_secs) & 16'h000f));
            check("running",  32'(running),  32'(m_mode == 1));
            check("rollover", 32'(rollover), 32'(m_roll));
        end
        $display("seg rst_n=%0b start=%0b pause=%0b clear=%0b len=%0d -> time=%04h run=%0b errs=%0d",
                 r, s, p, c, len, time_bcd, running, n_bad - bad0);
    endtask

    initial begin
        model_reset_hist();
        run_seg(0, 0, 0, 0, 2);      // reset
        run_seg(1, 1, 0, 0, 60);     // run from 00:00
        run_seg(1, 1, 1, 0, 20);     // pause with start still high
        run_seg(1, 1, 0, 0, 30);     // resume the partial second
        run_seg(1, 1, 0, 1, 10);     // clear beats start
        run_seg(1, 1, 0, 0, 40);     // restart from 00:00
        run_seg(1, 1, 0, 0, 110);    // reach 00:37 region
        run_seg(0, 1, 0, 0, 1);      // mid-run reset
        run_seg(1, 1, 0, 0, 30);     // re-enter RUN after sync delay
        run_seg(1, 0, 0, 1, 3);      // clear
        run_seg(1, 1, 0, 0, 14500);  // through 59:59
        run_seg(1, 0, 0, 0, 20);     // commands low: hold state
        check("rollover_count", 32'(dut_roll_cnt), 32'(m_roll_cnt));
        check("saw_wrap", 32'(m_roll_cnt > 0), 32'(!SAT));
        for (int i = 0; i < 40; i++) begin
            bit r, s, p, c;
            r = ($urandom % 25) != 0;
            s = ($urandom % 4) != 0;
            p = ($urandom % 4) == 0;
            c = ($urandom % 8) == 0;
            run_seg(r, s, p, c, 1 + int'($urandom % 60));
        end
        check("rollover_count_end", 32'(dut_roll_cnt), 32'(m_roll_cnt));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch.md
Name: stopwatch

Overview:
- Free-running MM:SS stopwatch driven by three keyboard-decoded command levels: start, pause and clear.
- Sits beside the PS/2 keyboard decoder. Exposes the seconds-units BCD digit on a 4-bit port for the LED/display path, plus the full 4-digit BCD time.
- Command inputs come from the PS/2 clock domain and are synchronised internally to clk.

Parameters:
- TICK_DIV, 50_000_000, number of clk cycles per counted second. Legal range is 2 or more; sim uses 4.
- SYNC_STAGES, 2, depth of the synchroniser on each command input. Legal range is 2 or more.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low system reset.
- start  in  1  run command level (asynchronous to clk).
- pause  in  1  pause command level (asynchronous to clk).
- clear  in  1  clear command level (asynchronous to clk); separate from reset_n.
- digit  out  4  seconds-units BCD digit, 0-9.
- time_bcd  out  16  {min_tens, min_units, sec_tens, sec_units}, each 4-bit BCD.
- running  out  1  high while in RUN.
- rollover  out  1  one-cycle pulse on wrap 59:59 -> 00:00.

Behaviour:
- Reset: when reset_n=0 at a clk edge, the following are cleared to 0:
  - all synchroniser flops, the prescaler and all four BCD digits;
  - the outputs digit, time_bcd, running and rollover.
  - The state machine goes to IDLE.
  - Reset has priority over every other input and takes effect mid-count.
- Synchronisation: start, pause and clear each pass through SYNC_STAGES flops. Decode uses the synchronised copies (s_start, s_pause, s_clear). Command-to-state latency is SYNC_STAGES+1 clk edges.
- Command priority: s_clear > s_pause > s_start. Inputs are levels, not pulses.
- States: IDLE, RUN, PAUSED.
  - Any state with s_clear=1 -> IDLE. Prescaler and digits are zeroed on that edge.
  - IDLE with s_start=1 and s_pause=0 -> RUN.
  - RUN with s_pause=1 -> PAUSED.
  - PAUSED with s_start=1 and s_pause=0 -> RUN.
  - All commands low -> hold the current state.
- Prescaler: counts 0..TICK_DIV-1 only in RUN.
  - At TICK_DIV-1 it wraps to 0 and generates an internal tick.
  - In PAUSED it holds its value, so resume continues the partial second.
  - In IDLE it is 0.
- Count: on each tick, sec_units increments.
  - Digit ranges: sec_units and min_units 0-9; sec_tens and min_tens 0-5.
  - Carry chain is BCD: each digit wraps to 0 and carries to the next on the same edge.
- Wrap (default build): 59:59 + tick -> 00:00, and rollover=1 for exactly that one cycle.
- Timing: outputs are registered.
  - digit equals time_bcd[3:0].
  - The first increment appears TICK_DIV edges after entering RUN.
- Clear while RUN: the count zeroes and the block sits in IDLE, even though s_start may still be high. It restarts only after s_clear falls and s_start=1 is seen, because IDLE->RUN requires s_clear=0.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined: on reaching 59:59 the count holds at 59:59 and the prescaler stops. The state stays RUN, rollover is never asserted, and only clear or reset_n returns the count to 00:00.
- Undefined: wrap behaviour as specified in Behaviour.

Test Plan:
- Reset: all inputs 0, reset_n=0 for 2 cycles -> digit=0, time_bcd=16'h0000, running=0, rollover=0.
- Run timing (TICK_DIV=4): raise start -> running=1 after 3 edges; digit=1 four edges later; digit=9 after 36 edges; the next tick gives time_bcd=16'h0010.
- Pause/resume: pause mid-second at prescaler=2 for 20 cycles -> digit frozen. Deassert pause with start still high -> next increment occurs 2 edges after RUN is re-entered.
- Clear priority: with start=1 and clear=1 both high -> time_bcd=0000 and running=0 held. Drop clear -> counting restarts from 00:00.
- Rollover: run to 59:59, then one tick -> time_bcd=16'h0000 with a single-cycle rollover=1. With STOPWATCH_SATURATE_EN defined, time_bcd stays at 16'h5959.
- Mid-run reset: reset_n=0 during RUN at 00:37 -> next edge shows time_bcd=0 and IDLE. With start still high after release, RUN is re-entered after the synchroniser delay.
